// File: rtl/usbls_tx_pkt_engine.sv
// usbls_tx_pkt_engine
//   Bit-level USB low/full-speed packet serialiser. Emits SYNC, PID, token
//   (addr/endp + CRC5), data payload (+ CRC16), zero-length data and
//   handshake packets with bit stuffing, NRZI and EOP. Also emits bare
//   keep-alive EOPs and bus reset (SE0 while make_reset is held).
// Ports:
//   clk, rst                 clock, async active-high reset
//   start/pkt_type/pid/tok_addr   packet request, latched when idle
//   data_valid/byte/last, data_ready   payload byte handshake
//   keep_alive, make_reset   bare EOP request / bus reset level
//   busy, done, err_underrun, err_overrun   status
//   dp_OUT, dn_OUT, dp_OE, dn_OE, EOP   pad drive
module usbls_tx_pkt_engine #(
  parameter int CLK_PER_BIT = 4,
  parameter int MAX_PAYLOAD = 8,
  parameter bit FULL_SPEED  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  pkt_type,
  input  logic [3:0]  pid,
  input  logic [10:0] tok_addr,
  input  logic        data_valid,
  input  logic [7:0]  data_byte,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        keep_alive,
  input  logic        make_reset,
  output logic        busy,
  output logic        done,
  output logic        err_underrun,
  output logic        err_overrun,
  output logic        dp_OUT,
  output logic        dn_OUT,
  output logic        dp_OE,
  output logic        dn_OE,
  output logic        EOP
);
  localparam int CW  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int NBW = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [NBW-1:0] NB_MAX  = NBW'(MAX_PAYLOAD);
  localparam logic J_DP = FULL_SPEED;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOK, S_CRC5, S_DATA, S_CRC16, S_UNDR, S_EOP, S_RST
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_idx, w_idx;
  logic [2:0]      r_ones, w_ones;
  logic            r_lvl, w_lvl;      // NRZI level, 1 = J
  logic            r_se0, w_se0;
  logic            r_oe, w_oe;
  logic            r_eop, w_eop;
  logic            r_done, w_done;
  logic            r_eu, w_eu;
  logic            r_eo, w_eo;
  logic [1:0]      r_type, w_type;
  logic [7:0]      r_pidb, w_pidb;
  logic [10:0]     r_tok, w_tok;
  logic [7:0]      r_byte, w_byte;
  logic [4:0]      r_crc5, w_crc5;
  logic [15:0]     r_crc16, w_crc16;
  logic [NBW-1:0]  r_nb, w_nb, w_nb1;
  logic            r_lastb, w_lastb;
  logic            r_ovr, w_ovr;
  logic            r_undr, w_undr;
  logic            w_tick, w_ready, w_bit, w_launch, w_count, w_fetch, w_stuffable;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_nb1  = r_nb + 1'b1;
  // Stuffing applies to every field after SYNC, and once more before EOP
  // when the last CRC bit completed a run of six ones.
  assign w_stuffable = (r_state inside {S_PID, S_TOK, S_CRC5, S_DATA, S_CRC16}) ||
                       (r_state == S_EOP && r_idx == 4'd0);

  always_comb begin
    w_state = r_state;  w_idx = r_idx;    w_ones = r_ones;  w_lvl = r_lvl;
    w_se0   = r_se0;    w_oe  = r_oe;     w_eop  = r_eop;
    w_done  = 1'b0;     w_eu  = 1'b0;     w_eo   = 1'b0;
    w_type  = r_type;   w_pidb = r_pidb;  w_tok  = r_tok;   w_byte = r_byte;
    w_crc5  = r_crc5;   w_crc16 = r_crc16; w_nb  = r_nb;    w_lastb = r_lastb;
    w_ovr   = r_ovr;    w_undr = r_undr;
    w_ready = 1'b0;     w_bit = 1'b1;     w_launch = 1'b0;  w_count = 1'b0;
    w_fetch = 1'b0;
    if (r_state == S_IDLE) begin
      w_ones = '0;
      if (start) begin
        w_state = S_SYNC;   w_idx = '0;
        w_type  = pkt_type; w_pidb = {~pid, pid}; w_tok = tok_addr;
        w_crc5  = '1;       w_crc16 = '1;
        w_nb    = '0;       w_lastb = 1'b0; w_ovr = 1'b0; w_undr = 1'b0;
      end else if (keep_alive) begin
        w_state = S_EOP;    w_idx = '0;
      end else if (make_reset) begin
        w_state = S_RST;
      end
    end else if (w_tick) begin
      if (w_stuffable && r_ones == 3'd6) begin
        // stuffed zero: field counters hold
        w_launch = 1'b1; w_bit = 1'b0; w_count = 1'b1;
      end else begin
        unique case (r_state)
          S_SYNC: begin
            w_launch = 1'b1; w_bit = (r_idx == 4'd7); w_idx = r_idx + 4'd1;
            if (r_idx == 4'd7) begin
              w_state = S_PID; w_idx = '0; w_ones = '0;
            end
          end
          S_PID: begin
            w_launch = 1'b1; w_count = 1'b1; w_bit = r_pidb[0];
            w_pidb = r_pidb >> 1; w_idx = r_idx + 4'd1;
            if (r_idx == 4'd7) begin
              w_idx = '0;
              unique case (r_type)
                2'd0: w_state = S_TOK;
                2'd1: w_fetch = 1'b1;
                2'd2: w_state = S_EOP;
                2'd3: w_state = S_CRC16;
              endcase
            end
          end
          S_TOK: begin
            w_launch = 1'b1; w_count = 1'b1; w_bit = r_tok[0];
            w_tok  = r_tok >> 1;
            w_crc5 = {r_crc5[3:0], 1'b0} ^ ((r_tok[0] ^ r_crc5[4]) ? 5'h05 : 5'h00);
            w_idx  = r_idx + 4'd1;
            if (r_idx == 4'd10) begin
              w_state = S_CRC5; w_idx = '0;
            end
          end
          S_CRC5: begin
            // remainder shifts out MSB first, complemented
            w_launch = 1'b1; w_count = 1'b1; w_bit = ~r_crc5[4];
            w_crc5 = {r_crc5[3:0], 1'b0}; w_idx = r_idx + 4'd1;
            if (r_idx == 4'd4) begin
              w_state = S_EOP; w_idx = '0;
            end
          end
          S_DATA: begin
            w_launch = 1'b1; w_count = 1'b1; w_bit = r_byte[0];
            w_byte  = r_byte >> 1;
            w_crc16 = {r_crc16[14:0], 1'b0} ^
                      ((r_byte[0] ^ r_crc16[15]) ? 16'h8005 : 16'h0000);
            w_idx = r_idx + 4'd1;
            if (r_idx == 4'd7) begin
              w_idx = '0;
              if (r_lastb) w_state = S_CRC16;
              else         w_fetch = 1'b1;
            end
          end
          S_CRC16: begin
            w_launch = 1'b1; w_count = 1'b1; w_bit = ~r_crc16[15];
            w_crc16 = {r_crc16[14:0], 1'b0}; w_idx = r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              w_state = S_EOP; w_idx = '0;
            end
          end
          S_UNDR: begin
            // deliberate unstuffed ones: receiver sees a bit-stuff error
            w_launch = 1'b1; w_bit = 1'b1; w_ones = '0; w_idx = r_idx + 4'd1;
            if (r_idx == 4'd7) begin
              w_state = S_EOP; w_idx = '0; w_undr = 1'b1;
            end
          end
          S_EOP: begin
            w_idx = r_idx + 4'd1;
            unique case (r_idx)
              4'd0: begin
                w_se0 = 1'b1; w_eop = 1'b1; w_oe = 1'b1;
                w_eu  = r_undr; w_undr = 1'b0;
              end
              4'd1: ;
              4'd2: begin
                w_se0 = 1'b0; w_eop = 1'b0; w_lvl = 1'b1;
              end
              default: begin
                w_oe = 1'b0; w_done = 1'b1; w_eo = r_ovr; w_ovr = 1'b0;
                w_state = S_IDLE; w_idx = '0;
              end
            endcase
          end
          S_RST: begin
            w_oe = 1'b1;
            if (make_reset) begin
              w_se0 = 1'b1;
            end else begin
              // one J bit, then finish through the EOP tail
              w_se0 = 1'b0; w_lvl = 1'b1; w_state = S_EOP; w_idx = 4'd3;
            end
          end
          default: ;
        endcase
      end

      if (w_launch) begin
        w_se0 = 1'b0; w_eop = 1'b0; w_oe = 1'b1;
        if (!w_bit)  w_lvl  = ~r_lvl;
        if (w_count) w_ones = w_bit ? r_ones + 3'd1 : 3'd0;
      end

      // next byte is taken on the tick that launches the previous last bit
      if (w_fetch) begin
        w_idx = '0;
        if (data_valid) begin
          w_ready = 1'b1;
          w_byte  = data_byte;
          w_nb    = w_nb1;
          w_lastb = data_last || (w_nb1 == NB_MAX);
          w_ovr   = !data_last && (w_nb1 == NB_MAX);
          w_state = S_DATA;
        end else begin
          w_state = S_UNDR;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE; r_cnt <= '0;  r_idx <= '0;  r_ones <= '0;
      r_lvl   <= 1'b1;   r_se0 <= 1'b0; r_oe <= 1'b0; r_eop <= 1'b0;
      r_done  <= 1'b0;   r_eu  <= 1'b0; r_eo <= 1'b0;
      r_type  <= '0;     r_pidb <= '0;  r_tok <= '0;  r_byte <= '0;
      r_crc5  <= '1;     r_crc16 <= '1; r_nb <= '0;
      r_lastb <= 1'b0;   r_ovr <= 1'b0; r_undr <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_state <= w_state; r_idx <= w_idx; r_ones <= w_ones; r_lvl <= w_lvl;
      r_se0   <= w_se0;   r_oe  <= w_oe;  r_eop  <= w_eop;
      r_done  <= w_done;  r_eu  <= w_eu;  r_eo   <= w_eo;
      r_type  <= w_type;  r_pidb <= w_pidb; r_tok <= w_tok; r_byte <= w_byte;
      r_crc5  <= w_crc5;  r_crc16 <= w_crc16; r_nb <= w_nb;
      r_lastb <= w_lastb; r_ovr <= w_ovr; r_undr <= w_undr;
    end
  end

  assign data_ready   = w_ready;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign err_underrun = r_eu;
  assign err_overrun  = r_eo;
  assign dp_OE        = r_oe;
  assign dn_OE        = r_oe;
  assign EOP          = r_eop;
  assign dp_OUT       = !r_se0 && (r_lvl ? J_DP : !J_DP);
  assign dn_OUT       = !r_se0 && (r_lvl ? !J_DP : J_DP);
endmodule

// File: tb/tb_usbls_tx_pkt_engine.sv
// Scoreboard bench: each request pushes the expected per-bit line symbols
// {EOP, OE, dp, dn}; the monitor pops one symbol per bit time.
module tb_usbls_tx_pkt_engine;
  localparam int CPB = 4, MAXP = 8;
  localparam logic [1:0] JS = 2'b01, KS = 2'b10;   // LS polarity

  logic clk = 1'b0, rst, start, data_valid, data_last, keep_alive, make_reset;
  logic [1:0] pkt_type;
  logic [3:0] pid;
  logic [10:0] tok_addr;
  logic [7:0] data_byte;
  logic data_ready, busy, done, err_underrun, err_overrun;
  logic dp_OUT, dn_OUT, dp_OE, dn_OE, EOP;

  always #5 clk = ~clk;

  usbls_tx_pkt_engine #(.CLK_PER_BIT(CPB), .MAX_PAYLOAD(MAXP), .FULL_SPEED(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_type(pkt_type), .pid(pid),
    .tok_addr(tok_addr), .data_valid(data_valid), .data_byte(data_byte),
    .data_last(data_last), .data_ready(data_ready), .keep_alive(keep_alive),
    .make_reset(make_reset), .busy(busy), .done(done),
    .err_underrun(err_underrun), .err_overrun(err_overrun),
    .dp_OUT(dp_OUT), .dn_OUT(dn_OUT), .dp_OE(dp_OE), .dn_OE(dn_OE), .EOP(EOP));

  int total = 0, bad = 0;
  logic [3:0] exp_q[$];
  logic [7:0] src_b[16];
  int rdy_tot = 0, eu_tot = 0, eu_off = 0;

  always @(negedge clk) begin
    if (data_ready) rdy_tot++;
    if (err_underrun) begin
      eu_tot++;
      if (!EOP) eu_off++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: reflected-form CRCs, stuffing, NRZI, EOP.
  task automatic build(input int typ, input logic [3:0] p, input logic [10:0] ta,
                       input int nvalid, input int last_i, input bit ka_only,
                       output int ntaken, output bit ovr, output bit undr);
    bit pl[$];
    bit ln[$];
    logic [7:0] pb;
    logic [4:0] c5;
    logic [15:0] c16;
    bit b, fb, lvl;
    int ones;
    ntaken = 0; ovr = 0; undr = 0;
    if (!ka_only) begin
      pb = {~p, p};
      for (int i = 0; i < 8; i++) pl.push_back(pb[i]);
      if (typ == 0) begin
        c5 = 5'h1f;
        for (int i = 0; i < 11; i++) begin
          b = ta[i]; pl.push_back(b);
          fb = b ^ c5[0]; c5 = c5 >> 1;
          if (fb) c5 ^= 5'h14;
        end
        c5 = ~c5;
        for (int i = 0; i < 5; i++) pl.push_back(c5[i]);
      end else if (typ == 1 || typ == 3) begin
        c16 = 16'hffff;
        if (typ == 1) begin
          for (int k = 0; k < MAXP; k++) begin
            if (k >= nvalid) begin undr = 1; break; end
            ntaken++;
            for (int i = 0; i < 8; i++) begin
              b = src_b[k][i]; pl.push_back(b);
              fb = b ^ c16[0]; c16 = c16 >> 1;
              if (fb) c16 ^= 16'ha001;
            end
            if (k == last_i) break;
            if (k == MAXP - 1) ovr = 1;
          end
        end
        if (!undr) begin
          c16 = ~c16;
          for (int i = 0; i < 16; i++) pl.push_back(c16[i]);
        end
      end
      for (int i = 0; i < 8; i++) ln.push_back(i == 7);
      ones = 0;
      foreach (pl[i]) begin
        ln.push_back(pl[i]);
        ones = pl[i] ? ones + 1 : 0;
        if (ones == 6) begin ln.push_back(1'b0); ones = 0; end
      end
      if (undr) for (int i = 0; i < 8; i++) ln.push_back(1'b1);
    end
    lvl = 1;
    foreach (ln[i]) begin
      if (!ln[i]) lvl = ~lvl;
      exp_q.push_back({2'b01, lvl ? JS : KS});
    end
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1100);
    exp_q.push_back({2'b01, JS});
  endtask

  task automatic run_pkt(input string tag, input int typ, input logic [3:0] p,
                         input logic [10:0] ta, input int nvalid, input int last_i,
                         input bit st, input bit ka);
    int ntaken, r0, e0, n, si;
    bit ovr, undr, stop;
    logic [3:0] e;
    build(typ, p, ta, nvalid, last_i, !st, ntaken, ovr, undr);
    r0 = rdy_tot; e0 = eu_tot; si = 0; stop = 0;
    @(posedge clk); #1;
    data_valid = (nvalid > 0); data_byte = src_b[0]; data_last = (last_i == 0);
    start = st; keep_alive = ka; pkt_type = typ[1:0]; pid = p; tok_addr = ta;
    @(posedge clk); #1;
    start = 0; keep_alive = 0; pid = ~p; tok_addr = ~ta; pkt_type = ~typ[1:0];
    fork
      begin : src
        logic r;
        while (!stop) begin
          @(negedge clk); r = data_ready;
          @(posedge clk); #1;
          if (r) si++;
          data_valid = (si < nvalid); data_byte = src_b[si % 16]; data_last = (si == last_i);
        end
      end
      begin : mon
        n = 0;
        while (!dp_OE && n < 200) begin @(negedge clk); n++; end
        if (!dp_OE) begin
          chk({tag, "_oe_timeout"}, 0, 1);
          exp_q.delete();
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_line"}, {EOP, dp_OE, dp_OUT, dn_OUT}, e);
          repeat (CPB) @(negedge clk);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_oe_off"}, {dp_OE, dn_OE}, 0);
        chk({tag, "_idle_line"}, {dp_OUT, dn_OUT}, JS);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, err_overrun, ovr);
        chk({tag, "_ready_cnt"}, rdy_tot - r0, ntaken);
        chk({tag, "_undr_cnt"}, eu_tot - e0, undr);
        stop = 1;
      end
    join
    data_valid = 0; data_last = 0;
  endtask

  initial begin
    int n;
    rst = 1; start = 0; data_valid = 0; data_last = 0; keep_alive = 0; make_reset = 0;
    pkt_type = 0; pid = 0; tok_addr = 0; data_byte = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_line", {EOP, dp_OE, dn_OE, dp_OUT, dn_OUT}, {3'b000, JS});
    chk("rst_status", {busy, done, err_underrun, err_overrun, data_ready}, 0);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy, dp_OE, dp_OUT, dn_OUT}, {2'b00, JS});

    run_pkt("ack", 2, 4'h2, 11'h0, 0, -1, 1, 0);
    run_pkt("setup0", 0, 4'hD, 11'h000, 0, -1, 1, 0);
    run_pkt("out_ff", 0, 4'h1, 11'h7FF, 0, -1, 1, 0);
    run_pkt("in_mix", 0, 4'h9, 11'h3A5, 0, -1, 1, 0);
    run_pkt("zld0", 3, 4'h3, 11'h0, 0, -1, 1, 0);
    src_b[0] = 8'hFF; src_b[1] = 8'hFF; src_b[2] = 8'hFF; src_b[3] = 8'h00;
    run_pkt("d1_ff", 1, 4'hB, 11'h0, 4, 3, 1, 0);
    src_b[0] = 8'h12; src_b[1] = 8'h34; src_b[2] = 8'hC6;
    run_pkt("d0_mix", 1, 4'h3, 11'h0, 3, 2, 1, 0);
    for (int i = 0; i < 16; i++) src_b[i] = 8'(i + 1);
    run_pkt("overrun", 1, 4'hB, 11'h0, 10, -1, 1, 0);
    src_b[0] = 8'h5A;
    run_pkt("undr_b2", 1, 4'hB, 11'h0, 1, -1, 1, 0);
    run_pkt("undr_b1", 1, 4'h3, 11'h0, 0, -1, 1, 0);
    chk("undr_at_eop", eu_off, 0);
    run_pkt("keepalive", 0, 4'h0, 11'h0, 0, -1, 0, 1);
    run_pkt("start_wins", 2, 4'hA, 11'h0, 0, -1, 1, 1);

    // bus reset
    @(posedge clk); #1 make_reset = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dp_OE && n < 50);
    chk("busrst_se0", {EOP, dp_OE, dp_OUT, dn_OUT}, 4'b0100);
    chk("busrst_busy", busy, 1);
    repeat (20) @(negedge clk);
    chk("busrst_hold", {EOP, dp_OE, dp_OUT, dn_OUT, busy}, 5'b01001);
    @(posedge clk); #1 make_reset = 0;
    n = 0;
    do begin @(negedge clk); n++; end while ({dp_OUT, dn_OUT} == 2'b00 && n < 20);
    chk("busrst_j", {EOP, dp_OE, dp_OUT, dn_OUT}, {2'b01, JS});
    repeat (CPB) @(negedge clk);
    chk("busrst_done", {done, dp_OE, busy}, 3'b100);

    // async reset mid-packet
    src_b[0] = 8'hA5;
    @(posedge clk); #1;
    data_valid = 1; data_byte = 8'hA5; start = 1; pkt_type = 2'd1; pid = 4'h3;
    @(posedge clk); #1 start = 0;
    repeat (60) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_line", {EOP, dp_OE, dn_OE, dp_OUT, dn_OUT}, {3'b000, JS});
    chk("arst_busy", busy, 0);
    @(posedge clk); #1 rst = 0; data_valid = 0;
    repeat (10) @(negedge clk);
    chk("arst_quiet", {busy, dp_OE, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
